// File: rtl/sw_arb_pkg.sv
// Shared codes and helpers for the stopwatch command arbiter.
// SW_ARB_HOST_PRIO_EN is the only build option; it is consumed by stopwatch_cmd_arbiter.
package sw_arb_pkg;

  localparam int unsigned CMD_W = 2;
  localparam int unsigned GAP_W = 8;

  localparam logic [CMD_W-1:0] CMD_NOP   = 2'b00;
  localparam logic [CMD_W-1:0] CMD_START = 2'b01;
  localparam logic [CMD_W-1:0] CMD_STOP  = 2'b10;
  localparam logic [CMD_W-1:0] CMD_RESET = 2'b11;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_RUNNING = 2'b01;
  localparam logic [1:0] ST_PAUSED  = 2'b10;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_GAP   = 2'd2
  } arb_state_t;

  // Command legality against the control FSM state; the invalid state 11 only admits reset.
  function automatic logic cmd_legal(input logic [CMD_W-1:0] cmd, input logic [1:0] st);
    logic ok;
    ok = 1'b0;
    case (cmd)
      CMD_START: ok = (st == ST_IDLE) || (st == ST_PAUSED);
      CMD_STOP:  ok = (st == ST_RUNNING);
      CMD_RESET: ok = 1'b1;
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Panel rising edges {reset,stop,start} to a single code; reset > stop > start.
  function automatic logic [CMD_W-1:0] edge_to_cmd(input logic [2:0] rise);
    logic [CMD_W-1:0] cmd;
    cmd = CMD_NOP;
    if (rise[2])      cmd = CMD_RESET;
    else if (rise[1]) cmd = CMD_STOP;
    else if (rise[0]) cmd = CMD_START;
    return cmd;
  endfunction

endpackage

// File: rtl/sw_arb_cmd_slot.sv
// Pending-command holding register: new commands overwrite start/stop, a held reset is sticky.
// A load in the same cycle as a clear is kept, so no edge is lost at grant time.
module sw_arb_cmd_slot
  import sw_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CMD_W-1:0] i_cmd,
  input  logic             i_clear,
  output logic [CMD_W-1:0] o_cmd,
  output logic             o_pending_c
);

  logic [CMD_W-1:0] r_cmd;
  logic [CMD_W-1:0] w_base;
  logic [CMD_W-1:0] w_nxt;

  always_comb begin
    w_base = i_clear ? CMD_NOP : r_cmd;
    w_nxt  = w_base;
    if (i_load && ((w_base != CMD_RESET) || (i_cmd == CMD_RESET))) begin
      w_nxt = i_cmd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cmd <= CMD_NOP;
    else        r_cmd <= w_nxt;
  end

  assign o_cmd       = r_cmd;
  assign o_pending_c = (r_cmd != CMD_NOP);

endmodule

// File: rtl/stopwatch_cmd_arbiter.sv
// Arbitrates panel buttons and a host port onto the stopwatch FSM start/stop/reset pulses.
// Build option: SW_ARB_HOST_PRIO_EN selects fixed host priority instead of round-robin.
module stopwatch_cmd_arbiter
  import sw_arb_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned REJ_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pnl_start,
  input  logic             pnl_stop,
  input  logic             pnl_reset,
  input  logic             host_valid,
  input  logic [1:0]       host_cmd,
  output logic             host_ready,
  input  logic [1:0]       fsm_state,
  output logic             start_o,
  output logic             stop_o,
  output logic             reset_o,
  output logic             grant_src,
  output logic             busy,
  output logic [REJ_W-1:0] rej_cnt
);

  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [GAP_W-1:0] w_gap_nxt;
  logic [2:0]       r_pnl_hist;
  logic [2:0]       w_rise;
  logic             w_pnl_load;
  logic [CMD_W-1:0] w_pnl_new;
  logic [CMD_W-1:0] w_pnl_cmd;
  logic             w_pnl_pend;
  logic [CMD_W-1:0] r_host_cmd;
  logic             r_host_rdy;
  logic             w_host_pend;
  logic             r_grant_src;
  logic             r_start;
  logic             r_stop;
  logic             r_reset;
  logic             r_busy;
  logic [REJ_W-1:0] r_rej_cnt;
  logic             w_sel_host;
  logic [CMD_W-1:0] w_sel_cmd;
  logic             w_grant;
  logic             w_reject;
  logic             w_clr_pnl;
  logic             w_clr_host;
`ifndef SW_ARB_HOST_PRIO_EN
  logic             r_rr_host;
`endif

  assign w_rise      = {pnl_reset, pnl_stop, pnl_start} & ~r_pnl_hist;
  assign w_pnl_load  = |w_rise;
  assign w_pnl_new   = edge_to_cmd(w_rise);
  assign w_host_pend = !r_host_rdy;

  sw_arb_cmd_slot u_pnl_slot (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_pnl_load),
    .i_cmd       (w_pnl_new),
    .i_clear     (w_clr_pnl),
    .o_cmd       (w_pnl_cmd),
    .o_pending_c (w_pnl_pend)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ARB_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Selection, legality filtering and gap sequencing.
  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap_cnt;
    w_sel_host  = 1'b0;
    w_sel_cmd   = CMD_NOP;
    w_grant     = 1'b0;
    w_reject    = 1'b0;
    w_clr_pnl   = 1'b0;
    w_clr_host  = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_pnl_pend && w_host_pend) begin
`ifdef SW_ARB_HOST_PRIO_EN
          w_sel_host = !((w_pnl_cmd == CMD_RESET) && (r_host_cmd != CMD_RESET));
`else
          w_sel_host = r_rr_host;
`endif
        end else begin
          w_sel_host = w_host_pend;
        end
        w_sel_cmd = w_sel_host ? r_host_cmd : w_pnl_cmd;
        if (w_pnl_pend || w_host_pend) begin
          w_clr_host = w_sel_host;
          w_clr_pnl  = !w_sel_host;
          if (cmd_legal(w_sel_cmd, fsm_state)) begin
            w_grant     = 1'b1;
            w_state_nxt = ARB_ISSUE;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      ARB_ISSUE: begin
        w_state_nxt = ARB_GAP;
        w_gap_nxt   = GAP_LOAD;
      end
      ARB_GAP: begin
        w_gap_nxt = GAP_W'(r_gap_cnt - GAP_W'(1));
        if (r_gap_cnt == GAP_W'(1)) w_state_nxt = ARB_IDLE;
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gap_cnt   <= '0;
      r_pnl_hist  <= '0;
      r_host_cmd  <= CMD_NOP;
      r_host_rdy  <= 1'b1;
      r_grant_src <= 1'b0;
      r_start     <= 1'b0;
      r_stop      <= 1'b0;
      r_reset     <= 1'b0;
      r_busy      <= 1'b0;
      r_rej_cnt   <= '0;
    end else begin
      r_gap_cnt  <= w_gap_nxt;
      r_pnl_hist <= {pnl_reset, pnl_stop, pnl_start};
      // Host nop is accepted but never occupies the slot.
      if (w_clr_host) begin
        r_host_cmd <= CMD_NOP;
        r_host_rdy <= 1'b1;
      end else if (host_valid && r_host_rdy && (host_cmd != CMD_NOP)) begin
        r_host_cmd <= host_cmd;
        r_host_rdy <= 1'b0;
      end
      if (w_grant) r_grant_src <= w_sel_host;
      r_start <= w_grant && (w_sel_cmd == CMD_START);
      r_stop  <= w_grant && (w_sel_cmd == CMD_STOP);
      r_reset <= w_grant && (w_sel_cmd == CMD_RESET);
      r_busy  <= (w_state_nxt != ARB_IDLE);
      if (w_reject && (r_rej_cnt != {REJ_W{1'b1}})) r_rej_cnt <= r_rej_cnt + REJ_W'(1);
    end
  end

`ifndef SW_ARB_HOST_PRIO_EN
  // Pointer favours whichever source was not granted last; panel after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_rr_host <= 1'b0;
    else if (w_grant) r_rr_host <= !w_sel_host;
  end
`endif

  assign host_ready = r_host_rdy;
  assign start_o    = r_start;
  assign stop_o     = r_stop;
  assign reset_o    = r_reset;
  assign grant_src  = r_grant_src;
  assign busy       = r_busy;
  assign rej_cnt    = r_rej_cnt;

endmodule
